// File: rtl/nx_fifo_rd_adapter.sv
// -----------------------------------------------------------------------------
// nx_fifo_rd_adapter
//
// Turns the read side of an nx_fifo (empty flag + head-of-FIFO data + pop
// strobe) into a valid/ready output stream. A two-entry prefetch buffer
// (head, tail) sustains one beat per cycle. The pop strobe depends only on
// registered occupancy and the upstream flags, never on out_ready.
//
// Optional feature: define NX_FIFO_RD_STATS_EN to build saturating counters
// for accepted beats and stall cycles. Without it both counter outputs are
// tied to zero and no counter flops exist.
//
// Parameters:
//   WIDTH      data width of FIFO read data and output stream
//   CNT_WIDTH  width of the statistics counters
//
// Ports:
//   clk          clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   clear        synchronous flush of the prefetch buffer
//   fifo_empty   upstream empty flag
//   fifo_rdata   upstream head data, valid while fifo_empty=0
//   fifo_ren     upstream pop strobe
//   out_valid    output stream valid
//   out_ready    output stream ready
//   out_data     output stream data (0 while the buffer is empty)
//   buf_cnt      prefetch buffer occupancy, 0..2
//   pop_count    accepted output beats (saturating)
//   stall_count  cycles with out_valid=1 and out_ready=0 (saturating)
// -----------------------------------------------------------------------------
module nx_fifo_rd_adapter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_ren,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           buf_cnt,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  // State encoding equals the occupancy, so buf_cnt is the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH-1:0] w_head_nxt;
  logic [WIDTH-1:0] w_tail_nxt;
  logic             r_run;
  logic             w_pop;
  logic             w_acc;

  // r_run holds off the first pop until the first edge after reset release.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Never pop when full, so TWO can only be left through an accept or clear.
  assign w_pop = r_run && !fifo_empty && !clear && (r_state != ST_TWO);
  assign w_acc = (r_state != ST_EMPTY) && out_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_head_nxt  = fifo_rdata;
          end
        end
        ST_ONE: begin
          if (w_pop && w_acc) begin
            w_head_nxt = fifo_rdata;
          end else if (w_pop) begin
            w_state_nxt = ST_TWO;
            w_tail_nxt  = fifo_rdata;
          end else if (w_acc) begin
            // Zero the head on emptying so out_data reads 0 straight from flops.
            w_state_nxt = ST_EMPTY;
            w_head_nxt  = '0;
          end
        end
        ST_TWO: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_head_nxt  = r_tail;
            w_tail_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_head_nxt  = '0;
          w_tail_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: the two buffer entries are reset because out_data must read 0
  // immediately on reset; a deeper storage array would normally be left
  // unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  assign fifo_ren  = w_pop;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_head;
  assign buf_cnt   = r_state;

`ifdef NX_FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] r_pop_count;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic                 w_stall;

  assign w_stall = (r_state != ST_EMPTY) && !out_ready;

  // Counters saturate at all-ones and are deliberately untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_acc && (r_pop_count != '1))     r_pop_count   <= r_pop_count + 1'b1;
      if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign pop_count   = r_pop_count;
  assign stall_count = r_stall_count;
`else
  assign pop_count   = '0;
  assign stall_count = '0;
`endif

endmodule
